// File: rtl/lab_pkg.sv
// Shared constants and types for the lab encoder/decoder family.
package lab_pkg;

   localparam int N_REQ = 32;
   localparam int IDX_W = 5;

   typedef enum logic {
      IDLE = 1'b0,
      OUT  = 1'b1
   } enc_state_t;

   // Decoder view of an index, used to build the clear mask for a granted bit.
   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/lab3_encoder_32x5_if.sv
// Request/grant bus between request sources, the encoder and its consumer.
interface lab3_encoder_32x5_if;
   import lab_pkg::*;

   logic [N_REQ-1:0] D;
   logic             enable;
   logic             ready;
   logic [IDX_W-1:0] A;
   logic             valid;
   logic [N_REQ-1:0] pending;
   logic             overrun;

   // master is the encoder that issues codes; slave is the source/consumer side.
   modport master (
      input  D, enable, ready,
      output A, valid, pending, overrun
   );

   modport slave (
      output D, enable, ready,
      input  A, valid, pending, overrun
   );

endinterface

// File: rtl/lab3_prio_enc_32.sv
// Combinational 32-to-5 priority encoder: highest set bit wins.
module lab3_prio_enc_32
   import lab_pkg::*;
(
   input  logic [N_REQ-1:0] pend,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Ascending scan so the last hit, the highest bit number, is kept.
   always_comb begin
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pend[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

   assign any = |pend;

endmodule

// File: rtl/lab3_encoder_32x5.sv
// Registered priority encoder: sticky pending requests drained one index per handshake.
module lab3_encoder_32x5
   import lab_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   lab3_encoder_32x5_if.master bus
);

   enc_state_t       state;
   logic [N_REQ-1:0] pend;
   logic [IDX_W-1:0] code;
   logic             overrun_flag;

   logic [IDX_W-1:0] top_idx;
   logic             any;
   logic             grant;
   logic [N_REQ-1:0] clr;
   logic [N_REQ-1:0] capt;

   lab3_prio_enc_32 prio (
      .pend (pend),
      .idx  (top_idx),
      .any  (any)
   );

   // A new index is taken whenever the output slot is empty or being accepted.
   assign grant = ((state == IDLE) || bus.ready) && any;
   assign clr   = grant ? onehot(top_idx) : '0;
   assign capt  = bus.enable ? bus.D : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         pend         <= '0;
         code         <= '0;
         overrun_flag <= 1'b0;
      end else begin
         pend <= (pend & ~clr) | capt;
         if (|(capt & pend & ~clr)) begin
            overrun_flag <= 1'b1;
         end
         if (state == IDLE) begin
            if (any) begin
               code  <= top_idx;
               state <= OUT;
            end
         end else if (bus.ready) begin
            if (any) begin
               code <= top_idx;
            end else begin
               state <= IDLE;
            end
         end
      end
   end

   assign bus.A       = code;
   assign bus.valid   = (state == OUT);
   assign bus.pending = pend;
   assign bus.overrun = overrun_flag;

endmodule

// File: tb/tb_lab3_encoder_32x5.sv
// Directed bench with an expected-index scoreboard for lab3_encoder_32x5.
module tb_lab3_encoder_32x5;
   import lab_pkg::*;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   logic [IDX_W-1:0] exp_q[$];

   lab3_encoder_32x5_if bus ();

   lab3_encoder_32x5 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: got %h expected %h", name, obs, exp);
      end
   endtask

   // Inputs change 2 time units after a rising edge, outputs are checked there too.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic apply_stimulus(input logic [31:0] d, input logic en, input logic rdy);
      bus.D      = d;
      bus.enable = en;
      bus.ready  = rdy;
   endtask

   // Every accepted code must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && bus.valid && bus.ready) begin
         if (exp_q.size() == 0) begin
            check_output("sb_unexpected_valid", 32'(bus.A), 32'hFFFF_FFFF);
         end else begin
            logic [IDX_W-1:0] e;
            e = exp_q.pop_front();
            check_output("sb_A", 32'(bus.A), 32'(e));
         end
      end
   end

   initial begin
      logic [31:0] prev_pulse;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      apply_stimulus(32'h0, 1'b1, 1'b1);
      step();
      step();
      check_output("rst_A", 32'(bus.A), 32'd0);
      check_output("rst_valid", 32'(bus.valid), 32'd0);
      check_output("rst_pending", bus.pending, 32'h0);
      check_output("rst_overrun", 32'(bus.overrun), 32'd0);
      rst_n = 1'b1;
      step();

      // single request on bit 0
      apply_stimulus(32'h0000_0001, 1'b1, 1'b1);
      exp_q.push_back(5'd0);
      step();
      apply_stimulus(32'h0, 1'b1, 1'b1);
      check_output("t1_pend_set", bus.pending, 32'h1);
      check_output("t1_valid_early", 32'(bus.valid), 32'd0);
      step();
      check_output("t1_valid", 32'(bus.valid), 32'd1);
      check_output("t1_A", 32'(bus.A), 32'd0);
      step();
      check_output("t1_valid_drop", 32'(bus.valid), 32'd0);
      check_output("t1_pending", bus.pending, 32'h0);
      check_output("t1_overrun", 32'(bus.overrun), 32'd0);

      // multi-hot issue order 31, 4, 0
      apply_stimulus(32'h8000_0011, 1'b1, 1'b1);
      exp_q.push_back(5'd31);
      exp_q.push_back(5'd4);
      exp_q.push_back(5'd0);
      step();
      apply_stimulus(32'h0, 1'b1, 1'b1);
      step();
      check_output("t2_A31", 32'(bus.A), 32'd31);
      check_output("t2_v31", 32'(bus.valid), 32'd1);
      step();
      check_output("t2_A4", 32'(bus.A), 32'd4);
      step();
      check_output("t2_A0", 32'(bus.A), 32'd0);
      check_output("t2_v0", 32'(bus.valid), 32'd1);
      step();
      check_output("t2_idle", 32'(bus.valid), 32'd0);

      // hold with ready low
      apply_stimulus(32'h0000_0200, 1'b1, 1'b0);
      exp_q.push_back(5'd9);
      step();
      apply_stimulus(32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         check_output("t3_hold_A", 32'(bus.A), 32'd9);
         check_output("t3_hold_valid", 32'(bus.valid), 32'd1);
      end
      apply_stimulus(32'h0, 1'b1, 1'b1);
      step();
      check_output("t3_release", 32'(bus.valid), 32'd0);

      // overrun: bit 7 waits behind bit 8 and is requested again
      apply_stimulus(32'h0000_0180, 1'b1, 1'b0);
      exp_q.push_back(5'd8);
      exp_q.push_back(5'd7);
      step();
      apply_stimulus(32'h0, 1'b1, 1'b0);
      step();
      check_output("t4_A8", 32'(bus.A), 32'd8);
      check_output("t4_pend7", bus.pending, 32'h0000_0080);
      check_output("t4_no_overrun", 32'(bus.overrun), 32'd0);
      apply_stimulus(32'h0000_0080, 1'b1, 1'b0);
      step();
      check_output("t4_overrun", 32'(bus.overrun), 32'd1);
      apply_stimulus(32'h0, 1'b1, 1'b1);
      step();
      check_output("t4_A7", 32'(bus.A), 32'd7);
      step();
      check_output("t4_drained", 32'(bus.valid), 32'd0);
      check_output("t4_sticky", 32'(bus.overrun), 32'd1);

      // capture disabled
      apply_stimulus(32'hFFFF_FFFF, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_output("t5_pending", bus.pending, 32'h0);
         check_output("t5_valid", 32'(bus.valid), 32'd0);
      end
      apply_stimulus(32'h0, 1'b1, 1'b1);

      // full walk 0..31, each code decodes back to its pulse
      prev_pulse = 32'h0;
      for (int i = 0; i < 32; i++) begin
         apply_stimulus(32'd1 << i, 1'b1, 1'b1);
         exp_q.push_back(IDX_W'(i));
         step();
         if (i > 0) begin
            check_output("t6_A", 32'(bus.A), 32'(i - 1));
            check_output("t6_decode", onehot(bus.A), prev_pulse);
         end
         prev_pulse = 32'd1 << i;
      end
      apply_stimulus(32'h0, 1'b1, 1'b1);
      step();
      check_output("t6_A31", 32'(bus.A), 32'd31);
      check_output("t6_decode31", onehot(bus.A), prev_pulse);
      step();
      check_output("t6_idle", 32'(bus.valid), 32'd0);
      check_output("t6_overrun", 32'(bus.overrun), 32'd1);

      // second walk interrupted by reset
      for (int i = 0; i < 12; i++) begin
         apply_stimulus(32'd1 << i, 1'b1, 1'b1);
         exp_q.push_back(IDX_W'(i));
         step();
      end
      check_output("t7_valid_before", 32'(bus.valid), 32'd1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_output("t7_valid_async", 32'(bus.valid), 32'd0);
      check_output("t7_pending_async", bus.pending, 32'h0);
      check_output("t7_A_async", 32'(bus.A), 32'd0);
      check_output("t7_overrun_async", 32'(bus.overrun), 32'd0);
      apply_stimulus(32'h0, 1'b1, 1'b1);
      step();
      rst_n = 1'b1;
      step();
      check_output("t7_after", 32'(bus.valid), 32'd0);
      check_output("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
